multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-subset CPU datapath. Supported instructions: R-type, addi, sltiu, beq, lui, ori, bne.
- Sequences each instruction through FETCH/DECODE/EXEC/WB.
- Drives PC write, IR write, register-file write, ALU op/source, destination select and branch PC source.
- Sits between the instruction register/ALU and the shared datapath; replaces single-cycle opcode decoding.

Parameters:
- CNT_W, 16: width of retired-instruction counter.
- FETCH_TIMEOUT, 8: max cycles waiting for imem_ready_i before fetch_err_o pulses and the wait count restarts (must be >= 2).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- imem_ready_i  in  1  instruction memory data valid this cycle.
- instr_op_i  in  6  opcode field from IR output.
- zero_i  in  1  ALU zero flag, valid in EXEC.
- PC_write_o  out  1  PC register load enable.
- PCSrc_o  out  1  0 = PC+4, 1 = branch target.
- IR_write_o  out  1  instruction register load enable.
- RegWrite_o  out  1  register-file write enable.
- ALU_op_o  out  3  ALU control class.
- ALUSrc_o  out  1  0 = rt register, 1 = immediate.
- RegDst_o  out  1  0 = rt, 1 = rd destination.
- instr_done_o  out  1  one-cycle pulse on instruction completion.
- illegal_o  out  1  one-cycle pulse in DECODE on unsupported opcode.
- fetch_err_o  out  1  one-cycle pulse on fetch timeout.
- state_o  out  2  current state (FETCH=0, DECODE=1, EXEC=2, WB=3).
- retired_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_i high at clock edge):
  - State goes to FETCH; op_q=0, wait_cnt=0, retired_o=0.
  - While rst_i is high, all 1-bit outputs and ALU_op_o are forced 0; state_o is driven as 0.
  - Reset mid-instruction aborts it with no further PC/IR/register writes.
- Opcode classes (op_q) and ALU_op_o encoding:
  - 000000 R-type -> 000; 001000 addi -> 001; 001011 sltiu -> 010; 000100 beq -> 011.
  - 001111 lui -> 100; 001101 ori -> 101; 000101 bne -> 110.
  - Any other opcode is illegal.
- Immediate class = addi, sltiu, lui, ori.
- FETCH:
  - If imem_ready_i=1: IR_write_o=1, PC_write_o=1, PCSrc_o=0, wait_cnt<=0, go to DECODE.
  - Else: wait_cnt increments. When wait_cnt reaches FETCH_TIMEOUT-1 with ready still low, fetch_err_o pulses that cycle, wait_cnt<=0, and the FSM stays in FETCH.
  - If imem_ready_i is high in the same cycle the timeout would fire, ready wins and no error is signalled.
- DECODE:
  - op_q <= instr_op_i.
  - Legal opcode: go to EXEC.
  - Illegal opcode: illegal_o=1, go to FETCH; instruction treated as NOP (no instr_done_o, counter unchanged).
- EXEC:
  - ALU_op_o, ALUSrc_o (1 for immediate class, else 0) and RegDst_o (1 for R-type) are decoded from op_q.
  - R-type or immediate class: go to WB.
  - beq: taken when zero_i=1. bne: taken when zero_i=0.
  - If taken: PC_write_o=1, PCSrc_o=1 (combinational on zero_i).
  - Branch (taken or not): instr_done_o=1, go to FETCH.
- WB:
  - ALU_op_o, ALUSrc_o and RegDst_o are held at their EXEC values; RegWrite_o=1, instr_done_o=1, go to FETCH.
- Outputs outside the states listed above are 0. ALU_op_o is 000 in FETCH and DECODE.
- Latency:
  - With ready in the first FETCH cycle: R/immediate = 4 cycles, branch = 3 cycles, illegal = 2 cycles.
  - Back-to-back instructions have no bubble.
- Counter: retired_o increments by 1 on each instr_done_o and wraps at 2^CNT_W-1 -> 0.
- RegWrite_o is never asserted in the same cycle as PC_write_o. IR_write_o is asserted only in FETCH.

Test Plan:
- Reset, then addi (001000) with imem_ready_i=1 -> state_o 0,1,2,3. EXEC/WB: ALU_op_o=001, ALUSrc_o=1. WB: RegWrite_o=1, instr_done_o=1. retired_o=1.
- R-type then ori, back to back -> WB of R-type: RegDst_o=1, ALU_op_o=000. WB of ori, 4 cycles later: ALU_op_o=101, ALUSrc_o=1, RegDst_o=0. retired_o=2.
- beq with zero_i=1, then bne with zero_i=1 -> beq EXEC: PC_write_o=1, PCSrc_o=1. bne EXEC: PC_write_o=0. Both pulse instr_done_o and take 3 cycles.
- imem_ready_i held low 20 cycles, FETCH_TIMEOUT=8 -> fetch_err_o pulses at cycles 8 and 16, state_o stays 0. Ready at cycle 21 -> IR_write_o=1.
- Opcode 100011 (lw) -> illegal_o pulse in DECODE, no RegWrite_o, retired_o unchanged, FETCH next cycle.
- rst_i asserted during WB of sltiu -> RegWrite_o=0 in that cycle, state_o=0 afterwards, retired_o=0. Also preload the counter to all-ones and retire once -> retired_o wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences FETCH/DECODE/EXEC/WB
// and drives the PC, IR, register-file and ALU controls for each instruction.
module multicycle_ctrl #(
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             imem_ready_i,
  input  logic [5:0]       instr_op_i,
  input  logic             zero_i,
  output logic             PC_write_o,
  output logic             PCSrc_o,
  output logic             IR_write_o,
  output logic             RegWrite_o,
  output logic [2:0]       ALU_op_o,
  output logic             ALUSrc_o,
  output logic             RegDst_o,
  output logic             instr_done_o,
  output logic             illegal_o,
  output logic             fetch_err_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  // Opcode class doubles as the ALU control code; the spare code marks illegal opcodes.
  typedef enum logic [2:0] {
    C_RTYPE   = 3'd0,
    C_ADDI    = 3'd1,
    C_SLTIU   = 3'd2,
    C_BEQ     = 3'd3,
    C_LUI     = 3'd4,
    C_ORI     = 3'd5,
    C_BNE     = 3'd6,
    C_ILLEGAL = 3'd7
  } op_class_t;

  localparam int                WAIT_W    = $clog2(FETCH_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

  function automatic op_class_t op_class(input logic [5:0] op);
    case (op)
      6'b000000: return C_RTYPE;
      6'b001000: return C_ADDI;
      6'b001011: return C_SLTIU;
      6'b000100: return C_BEQ;
      6'b001111: return C_LUI;
      6'b001101: return C_ORI;
      6'b000101: return C_BNE;
      default:   return C_ILLEGAL;
    endcase
  endfunction

  state_t            r_state;
  logic [5:0]        r_op_q;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_retired;

  op_class_t w_in_cls;
  op_class_t w_q_cls;
  logic      w_q_imm;
  logic      w_q_branch;
  logic      w_taken;

  assign w_in_cls   = op_class(instr_op_i);
  assign w_q_cls    = op_class(r_op_q);
  assign w_q_imm    = (w_q_cls == C_ADDI) || (w_q_cls == C_SLTIU) ||
                      (w_q_cls == C_LUI)  || (w_q_cls == C_ORI);
  assign w_q_branch = (w_q_cls == C_BEQ) || (w_q_cls == C_BNE);
  assign w_taken    = (w_q_cls == C_BEQ) ? zero_i : !zero_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_FETCH;
      r_op_q     <= '0;
      r_wait_cnt <= '0;
      r_retired  <= '0;
    end else begin
      if (instr_done_o) r_retired <= r_retired + 1'b1;
      case (r_state)
        S_FETCH: begin
          if (imem_ready_i) begin
            r_wait_cnt <= '0;
            r_state    <= S_DECODE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          r_op_q  <= instr_op_i;
          r_state <= (w_in_cls == C_ILLEGAL) ? S_FETCH : S_EXEC;
        end
        S_EXEC:  r_state <= w_q_branch ? S_FETCH : S_WB;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    PC_write_o   = 1'b0;
    PCSrc_o      = 1'b0;
    IR_write_o   = 1'b0;
    RegWrite_o   = 1'b0;
    ALU_op_o     = 3'b000;
    ALUSrc_o     = 1'b0;
    RegDst_o     = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    fetch_err_o  = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_FETCH: begin
          IR_write_o  = imem_ready_i;
          PC_write_o  = imem_ready_i;
          fetch_err_o = !imem_ready_i && (r_wait_cnt == WAIT_LAST);
        end
        S_DECODE: illegal_o = (w_in_cls == C_ILLEGAL);
        S_EXEC: begin
          ALU_op_o = w_q_cls;
          ALUSrc_o = w_q_imm;
          RegDst_o = (w_q_cls == C_RTYPE);
          if (w_q_branch) begin
            instr_done_o = 1'b1;
            PC_write_o   = w_taken;
            PCSrc_o      = w_taken;
          end
        end
        default: begin
          ALU_op_o     = w_q_cls;
          ALUSrc_o     = w_q_imm;
          RegDst_o     = (w_q_cls == C_RTYPE);
          RegWrite_o   = 1'b1;
          instr_done_o = 1'b1;
        end
      endcase
    end
  end

  assign state_o   = rst_i ? 2'd0 : r_state;
  assign retired_o = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-cycle vector table fed through a
// scoreboard queue, plus hand-written sequences on a narrow instance for wrap/timeout.
module tb_multicycle_ctrl;

  localparam int CNT_W = 16;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // {PC_write, PCSrc, IR_write, RegWrite}
  localparam logic [3:0] NW = 4'b0000;
  localparam logic [3:0] FE = 4'b1010;
  localparam logic [3:0] BR = 4'b1100;
  localparam logic [3:0] RW = 4'b0001;
  // {instr_done, illegal, fetch_err}
  localparam logic [2:0] P0 = 3'b000;
  localparam logic [2:0] PD = 3'b100;
  localparam logic [2:0] PI = 3'b010;
  localparam logic [2:0] PF = 3'b001;

  typedef struct packed {
    logic [1:0]       st;
    logic             pcw, pcs, irw, rw;
    logic [2:0]       aop;
    logic             asrc, rdst;
    logic             done, ill, ferr;
    logic [CNT_W-1:0] ret;
  } out_t;

  typedef struct {
    logic       rst, rdy;
    logic [5:0] op;
    logic       z;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, rdy, zero;
  logic [5:0]       op;
  logic             pcw, pcs, irw, rw, asrc, rdst, done, ill, ferr;
  logic [2:0]       aop;
  logic [1:0]       st;
  logic [CNT_W-1:0] ret;

  logic       w_rst, w_rdy, w_zero;
  logic [5:0] w_op;
  logic       w_pcw, w_pcs, w_irw, w_rw, w_asrc, w_rdst, w_done, w_ill, w_ferr;
  logic [2:0] w_aop;
  logic [1:0] w_st;
  logic [1:0] w_ret;

  multicycle_ctrl #(.CNT_W(CNT_W), .FETCH_TIMEOUT(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .imem_ready_i(rdy), .instr_op_i(op), .zero_i(zero),
    .PC_write_o(pcw), .PCSrc_o(pcs), .IR_write_o(irw), .RegWrite_o(rw),
    .ALU_op_o(aop), .ALUSrc_o(asrc), .RegDst_o(rdst), .instr_done_o(done),
    .illegal_o(ill), .fetch_err_o(ferr), .state_o(st), .retired_o(ret)
  );

  multicycle_ctrl #(.CNT_W(2), .FETCH_TIMEOUT(2)) u_wrap (
    .clk_i(clk), .rst_i(w_rst), .imem_ready_i(w_rdy), .instr_op_i(w_op), .zero_i(w_zero),
    .PC_write_o(w_pcw), .PCSrc_o(w_pcs), .IR_write_o(w_irw), .RegWrite_o(w_rw),
    .ALU_op_o(w_aop), .ALUSrc_o(w_asrc), .RegDst_o(w_rdst), .instr_done_o(w_done),
    .illegal_o(w_ill), .fetch_err_o(w_ferr), .state_o(w_st), .retired_o(w_ret)
  );

  vec_t  vecs[$];
  string names[$];
  vec_t  sb[$];
  string sb_names[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input string n, input logic r, input logic rd, input logic [5:0] o,
                              input logic z, input logic [1:0] s, input logic [3:0] wr,
                              input logic [2:0] a, input logic [1:0] sd, input logic [2:0] pl,
                              input int rt);
    vec_t v;
    v.rst = r; v.rdy = rd; v.op = o; v.z = z;
    v.exp = '{st: s, pcw: wr[3], pcs: wr[2], irw: wr[1], rw: wr[0], aop: a,
              asrc: sd[1], rdst: sd[0], done: pl[2], ill: pl[1], ferr: pl[0],
              ret: rt[CNT_W-1:0]};
    vecs.push_back(v);
    names.push_back(n);
  endfunction

  function automatic out_t sample();
    return '{st: st, pcw: pcw, pcs: pcs, irw: irw, rw: rw, aop: aop, asrc: asrc,
             rdst: rdst, done: done, ill: ill, ferr: ferr, ret: ret};
  endfunction

  // Drive one cycle's inputs after the falling edge, then compare before the rising edge.
  task automatic apply(input vec_t v, input string n);
    vec_t  e;
    string en;
    @(negedge clk);
    rst = v.rst; rdy = v.rdy; op = v.op; zero = v.z;
    sb.push_back(v);
    sb_names.push_back(n);
    #2;
    e  = sb.pop_front();
    en = sb_names.pop_front();
    check(en, 64'(sample()), 64'(e.exp));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; op = OP_R; zero = 1'b0;
    w_rst = 1'b1; w_rdy = 1'b0; w_op = OP_R; w_zero = 1'b0;

    add("reset_forced", 1, 1, OP_ADDI, 1, 0, NW, 3'b000, 2'b00, P0, 0);
    add("addi_fetch",   0, 1, OP_R,    0, 0, FE, 3'b000, 2'b00, P0, 0);
    add("addi_decode",  0, 0, OP_ADDI, 0, 1, NW, 3'b000, 2'b00, P0, 0);
    add("addi_exec",    0, 0, OP_ADDI, 0, 2, NW, 3'b001, 2'b10, P0, 0);
    add("addi_wb",      0, 0, OP_ADDI, 0, 3, RW, 3'b001, 2'b10, PD, 0);
    add("r_fetch",      0, 1, OP_R,    0, 0, FE, 3'b000, 2'b00, P0, 1);
    add("r_decode",     0, 0, OP_R,    0, 1, NW, 3'b000, 2'b00, P0, 1);
    add("r_exec",       0, 0, OP_R,    0, 2, NW, 3'b000, 2'b01, P0, 1);
    add("r_wb",         0, 0, OP_R,    0, 3, RW, 3'b000, 2'b01, PD, 1);
    add("ori_fetch",    0, 1, OP_ORI,  0, 0, FE, 3'b000, 2'b00, P0, 2);
    add("ori_decode",   0, 0, OP_ORI,  0, 1, NW, 3'b000, 2'b00, P0, 2);
    add("ori_exec",     0, 0, OP_ORI,  0, 2, NW, 3'b101, 2'b10, P0, 2);
    add("ori_wb",       0, 0, OP_ORI,  0, 3, RW, 3'b101, 2'b10, PD, 2);
    add("beq1_fetch",   0, 1, OP_BEQ,  1, 0, FE, 3'b000, 2'b00, P0, 3);
    add("beq1_decode",  0, 0, OP_BEQ,  1, 1, NW, 3'b000, 2'b00, P0, 3);
    add("beq1_exec",    0, 0, OP_BEQ,  1, 2, BR, 3'b011, 2'b00, PD, 3);
    add("bne1_fetch",   0, 1, OP_BNE,  1, 0, FE, 3'b000, 2'b00, P0, 4);
    add("bne1_decode",  0, 0, OP_BNE,  1, 1, NW, 3'b000, 2'b00, P0, 4);
    add("bne1_exec",    0, 0, OP_BNE,  1, 2, NW, 3'b110, 2'b00, PD, 4);
    add("bne0_fetch",   0, 1, OP_BNE,  0, 0, FE, 3'b000, 2'b00, P0, 5);
    add("bne0_decode",  0, 0, OP_BNE,  0, 1, NW, 3'b000, 2'b00, P0, 5);
    add("bne0_exec",    0, 0, OP_BNE,  0, 2, BR, 3'b110, 2'b00, PD, 5);
    add("beq0_fetch",   0, 1, OP_BEQ,  0, 0, FE, 3'b000, 2'b00, P0, 6);
    add("beq0_decode",  0, 0, OP_BEQ,  0, 1, NW, 3'b000, 2'b00, P0, 6);
    add("beq0_exec",    0, 0, OP_BEQ,  0, 2, NW, 3'b011, 2'b00, PD, 6);
    add("lw_fetch",     0, 1, OP_LW,   0, 0, FE, 3'b000, 2'b00, P0, 7);
    add("lw_illegal",   0, 0, OP_LW,   0, 1, NW, 3'b000, 2'b00, PI, 7);
    add("lui_fetch",    0, 1, OP_LUI,  0, 0, FE, 3'b000, 2'b00, P0, 7);
    add("lui_decode",   0, 0, OP_LUI,  0, 1, NW, 3'b000, 2'b00, P0, 7);
    add("lui_exec",     0, 0, OP_LUI,  0, 2, NW, 3'b100, 2'b10, P0, 7);
    add("lui_wb",       0, 0, OP_LUI,  0, 3, RW, 3'b100, 2'b10, PD, 7);
    for (int c = 1; c <= 20; c++)
      add($sformatf("timeout_c%0d", c), 0, 0, OP_R, 0, 0, NW, 3'b000, 2'b00,
          (c == 8 || c == 16) ? PF : P0, 8);
    add("timeout_ready",  0, 1, OP_SLTIU, 0, 0, FE, 3'b000, 2'b00, P0, 8);
    add("sltiu_decode",   0, 0, OP_SLTIU, 0, 1, NW, 3'b000, 2'b00, P0, 8);
    add("sltiu_exec",     0, 0, OP_SLTIU, 0, 2, NW, 3'b010, 2'b10, P0, 8);
    add("sltiu_wb_reset", 1, 0, OP_SLTIU, 0, 0, NW, 3'b000, 2'b00, P0, 8);
    for (int c = 1; c <= 7; c++)
      add($sformatf("post_reset_wait%0d", c), 0, 0, OP_BAD, 0, 0, NW, 3'b000, 2'b00, P0, 0);
    add("ready_wins",     0, 1, OP_BAD, 0, 0, FE, 3'b000, 2'b00, P0, 0);
    add("bad_illegal",    0, 0, OP_BAD, 0, 1, NW, 3'b000, 2'b00, PI, 0);
    add("bad_back_fetch", 0, 0, OP_BAD, 0, 0, NW, 3'b000, 2'b00, P0, 0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], names[i]);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    // Narrow instance: 2-bit counter wrap and the minimum fetch timeout.
    @(negedge clk); w_rst = 1'b0; w_rdy = 1'b0;
    #2 check("wrap_reset_ret", 64'(w_ret), 64'd0);
    check("wrap_to1_ferr", 64'(w_ferr), 64'd0);
    @(negedge clk); #2 check("wrap_to2_ferr", 64'(w_ferr), 64'd1);
    @(negedge clk); #2 check("wrap_to3_ferr", 64'(w_ferr), 64'd0);
    @(negedge clk); #2 check("wrap_to4_ferr", 64'(w_ferr), 64'd1);
    check("wrap_to_state", 64'(w_st), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); w_rdy = 1'b1; w_op = OP_BEQ;
      #2 check($sformatf("wrap_fetch%0d_irw", k), 64'(w_irw), 64'd1);
      @(negedge clk); w_rdy = 1'b0;
      #2 check($sformatf("wrap_decode%0d_state", k), 64'(w_st), 64'd1);
      @(negedge clk);
      #2 check($sformatf("wrap_exec%0d_done", k), 64'(w_done), 64'd1);
      check($sformatf("wrap_exec%0d_ret", k), 64'(w_ret), 64'(k));
    end
    @(negedge clk); #2 check("wrap_ret_wrapped", 64'(w_ret), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
